// File: rtl/controle_senhas_pkg.sv
// Shared types and constants for the bomb-clock game controller.
package pacote_senhas;

    typedef enum logic [2:0] {
        OCIOSO,
        FASE_A,
        FASE_B,
        DESARMADA_S,
        EXPLODIDA
    } estado_t;

    localparam logic [7:0] LFSR_SEMENTE = 8'hA5;
    // x^8+x^6+x^5+x^4+1 -> taps on bits 7,5,4,3 of a left-shifting register
    localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;

    function automatic logic [7:0] lfsr_passo(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/controle_senhas_if.sv
// Player-side and display-side signals of the game controller.
interface controle_senhas_if;
    logic       ENABLE;
    logic       START;
    logic       ENTER;
    logic [3:0] TENTATIVA;
    logic [3:0] A;
    logic [2:0] B;
    logic       ACERTOU_SENHA_A;
    logic       DESARMADA;
    logic       EXPLODIU;
    logic       ENTER_VALIDO;
    logic [3:0] TENTATIVAS_RESTANTES;

    modport master (
        output ENABLE, START, ENTER, TENTATIVA,
        input  A, B, ACERTOU_SENHA_A, DESARMADA, EXPLODIU, ENTER_VALIDO,
               TENTATIVAS_RESTANTES
    );

    modport slave (
        input  ENABLE, START, ENTER, TENTATIVA,
        output A, B, ACERTOU_SENHA_A, DESARMADA, EXPLODIU, ENTER_VALIDO,
               TENTATIVAS_RESTANTES
    );
endinterface

// File: rtl/controle_senhas_sincroniza_botao.sv
// Pushbutton conditioning: 2-flop synchronizer, stable-high counter, one pulse per press.
module sincroniza_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic BOTAO,
    output logic PULSO
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    logic          s1, s2;
    logic          armado;
    logic [CW-1:0] cont;

    // armado drops after the pulse and only returns on a synchronized low sample
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            armado <= 1'b1;
            cont   <= '0;
            PULSO  <= 1'b0;
        end else begin
            s1 <= BOTAO;
            s2 <= s1;
            if (!s2) begin
                armado <= 1'b1;
                cont   <= '0;
                PULSO  <= 1'b0;
            end else if (armado && cont == ULTIMO) begin
                armado <= 1'b0;
                PULSO  <= 1'b1;
            end else begin
                if (armado) cont <= cont + 1'b1;
                PULSO <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/controle_senhas.sv
// Bomb-clock game control: secret draw, attempt judging, phase/attempt tracking.
module controle_senhas
    import pacote_senhas::*;
#(
    parameter int MAX_TENTATIVAS  = 8,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic               CLOCK,
    input  logic               RESET,
    controle_senhas_if.slave   io
);
    localparam logic [3:0] MAX = 4'(MAX_TENTATIVAS);

    estado_t    estado, estado_n;
    logic [7:0] lfsr;
    logic [3:0] a_q, a_n;
    logic [2:0] b_q, b_n;
    logic [3:0] rest_q, rest_n;
    logic       acertou_q, acertou_n;
    logic       desarm_q, explod_q;
    logic       enter_valido;
    logic       acerto;

    sincroniza_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_enter (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .BOTAO (io.ENTER),
        .PULSO (enter_valido)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            estado    <= OCIOSO;
            lfsr      <= LFSR_SEMENTE;
            a_q       <= '0;
            b_q       <= '0;
            rest_q    <= MAX;
            acertou_q <= 1'b0;
            desarm_q  <= 1'b0;
            explod_q  <= 1'b0;
        end else begin
            estado    <= estado_n;
            lfsr      <= lfsr_passo(lfsr);
            a_q       <= a_n;
            b_q       <= b_n;
            rest_q    <= rest_n;
            acertou_q <= acertou_n;
            desarm_q  <= (estado_n == DESARMADA_S);
            explod_q  <= (estado_n == EXPLODIDA);
        end
    end

    // phase B only looks at the low three switches
    assign acerto = (estado == FASE_A) ? (io.TENTATIVA == a_q)
                                       : (io.TENTATIVA[2:0] == b_q);

    always_comb begin
        estado_n  = estado;
        a_n       = a_q;
        b_n       = b_q;
        rest_n    = rest_q;
        acertou_n = acertou_q;
        case (estado)
            OCIOSO: begin
                if (io.ENABLE && io.START) begin
                    a_n      = lfsr[3:0];
                    b_n      = lfsr[6:4];
                    rest_n   = MAX;
                    estado_n = FASE_A;
                end
            end
            FASE_A, FASE_B: begin
                if (io.ENABLE && enter_valido) begin
                    if (acerto) begin
                        rest_n = MAX;
                        if (estado == FASE_A) begin
                            acertou_n = 1'b1;
                            estado_n  = FASE_B;
                        end else begin
                            estado_n  = DESARMADA_S;
                        end
                    end else if (rest_q == 4'd1) begin
                        rest_n   = 4'd0;
                        estado_n = EXPLODIDA;
                    end else begin
                        rest_n = rest_q - 4'd1;
                    end
                end
            end
            DESARMADA_S, EXPLODIDA: begin
                if (io.ENABLE && io.START) begin
                    acertou_n = 1'b0;
                    estado_n  = OCIOSO;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_comb begin
        io.A                    = a_q;
        io.B                    = b_q;
        io.ACERTOU_SENHA_A      = acertou_q;
        io.DESARMADA            = desarm_q;
        io.EXPLODIU             = explod_q;
        io.ENTER_VALIDO         = enter_valido;
        io.TENTATIVAS_RESTANTES = rest_q;
    end
endmodule

// File: tb/tb_controle_senhas.sv
// Bench: two controllers (8 and 2 attempts) share one stimulus stream, checked against a game model.
module tb_controle_senhas;
    localparam int DEB = 4;
    localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_WIN = 3, P_BOOM = 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       enable = 1'b0, start = 1'b0, enter = 1'b0;
    logic [3:0] tent = 4'd0;

    int total = 0;
    int bad   = 0;

    controle_senhas_if bus0();
    controle_senhas_if bus1();

    assign bus0.ENABLE = enable;
    assign bus0.START = start;
    assign bus0.ENTER = enter;
    assign bus0.TENTATIVA = tent;
    assign bus1.ENABLE = enable;
    assign bus1.START = start;
    assign bus1.ENTER = enter;
    assign bus1.TENTATIVA = tent;

    controle_senhas #(.MAX_TENTATIVAS(8), .DEBOUNCE_CICLOS(DEB)) dut0 (
        .CLOCK (CLOCK), .RESET (RESET), .io (bus0));
    controle_senhas #(.MAX_TENTATIVAS(2), .DEBOUNCE_CICLOS(DEB)) dut1 (
        .CLOCK (CLOCK), .RESET (RESET), .io (bus1));

    always #5 CLOCK = ~CLOCK;

    // Reference LFSR: value present in the register before each rising edge
    logic [7:0] m_lfsr;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int         maxv [2] = '{8, 2};
    int         m_ph [2];
    logic [3:0] m_a  [2];
    logic [2:0] m_b  [2];
    int         m_rem[2];
    bit         m_ok [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = P_IDLE; m_a[i] = 4'd0; m_b[i] = 3'd0;
            m_rem[i] = maxv[i]; m_ok[i] = 1'b0;
        end
    endtask

    task automatic model_start(input logic [7:0] l);
        if (!enable) return;
        for (int i = 0; i < 2; i++) begin
            if (m_ph[i] == P_IDLE) begin
                m_a[i] = l[3:0]; m_b[i] = l[6:4]; m_rem[i] = maxv[i]; m_ph[i] = P_A;
            end else if (m_ph[i] == P_WIN || m_ph[i] == P_BOOM) begin
                m_ph[i] = P_IDLE; m_ok[i] = 1'b0;
            end
        end
    endtask

    task automatic model_press(input logic [3:0] t);
        bit hit;
        if (!enable) return;
        for (int i = 0; i < 2; i++) begin
            if (m_ph[i] == P_A || m_ph[i] == P_B) begin
                hit = (m_ph[i] == P_A) ? (t == m_a[i]) : (t[2:0] == m_b[i]);
                if (hit) begin
                    m_rem[i] = maxv[i];
                    if (m_ph[i] == P_A) begin m_ok[i] = 1'b1; m_ph[i] = P_B; end
                    else m_ph[i] = P_WIN;
                end else if (m_rem[i] == 1) begin
                    m_rem[i] = 0; m_ph[i] = P_BOOM;
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string w, input int i, input logic [3:0] a, input logic [2:0] b,
                           input logic ok, input logic d, input logic e, input logic ev,
                           input logic [3:0] rem);
        chk($sformatf("%s.dut%0d.A", w, i), 32'(a), 32'(m_a[i]));
        chk($sformatf("%s.dut%0d.B", w, i), 32'(b), 32'(m_b[i]));
        chk($sformatf("%s.dut%0d.ACERTOU", w, i), 32'(ok), 32'(m_ok[i]));
        chk($sformatf("%s.dut%0d.DESARMADA", w, i), 32'(d), 32'(m_ph[i] == P_WIN));
        chk($sformatf("%s.dut%0d.EXPLODIU", w, i), 32'(e), 32'(m_ph[i] == P_BOOM));
        chk($sformatf("%s.dut%0d.ENTER_VALIDO", w, i), 32'(ev), 32'd0);
        if (m_ph[i] != P_WIN)
            chk($sformatf("%s.dut%0d.RESTANTES", w, i), 32'(rem), 32'(m_rem[i]));
    endtask

    task automatic chk_all(input string w);
        chk_dut(w, 0, bus0.A, bus0.B, bus0.ACERTOU_SENHA_A, bus0.DESARMADA, bus0.EXPLODIU,
                bus0.ENTER_VALIDO, bus0.TENTATIVAS_RESTANTES);
        chk_dut(w, 1, bus1.A, bus1.B, bus1.ACERTOU_SENHA_A, bus1.DESARMADA, bus1.EXPLODIU,
                bus1.ENTER_VALIDO, bus1.TENTATIVAS_RESTANTES);
    endtask

    task automatic do_start(input string w);
        logic [7:0] l;
        @(negedge CLOCK);
        l = m_lfsr;
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        model_start(l);
        chk_all(w);
    endtask

    // One press: latency and width of ENTER_VALIDO, then the verdict; optional long hold
    task automatic press(input string w, input logic [3:0] t, input bit start_on_pulse,
                         input int hold);
        int k;
        int extra;
        logic [7:0] l;
        tent = t;
        @(negedge CLOCK);
        enter = 1'b1;
        k = 0;
        while (!bus0.ENTER_VALIDO && k < 20) begin
            @(negedge CLOCK);
            k++;
        end
        chk({w, ".latency"}, 32'(k), 32'(DEB + 2));
        chk({w, ".pulse1"}, 32'(bus1.ENTER_VALIDO), 32'd1);
        l = m_lfsr;
        if (start_on_pulse) start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        if (k < 20) begin
            if (start_on_pulse) model_start(l);
            else model_press(t);
        end
        chk_all(w);
        extra = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge CLOCK);
            if (bus0.ENTER_VALIDO || bus1.ENTER_VALIDO) extra++;
        end
        if (hold > 0) chk({w, ".no_repeat"}, 32'(extra), 32'd0);
        enter = 1'b0;
        repeat (4) @(negedge CLOCK);
    endtask

    function automatic logic [3:0] wrong_a();
        logic [3:0] t;
        do t = 4'($urandom_range(0, 15)); while (t == m_a[0] || t == m_a[1]);
        return t;
    endfunction

    initial begin
        int cnt;
        logic [3:0] t;
        logic [7:0] l;

        enable = 1'b1;
        model_reset();
        repeat (3) @(negedge CLOCK);
        chk_all("reset");

        // release reset with START already high: first edge draws from 8'hA5
        RESET = 1'b1;
        l = m_lfsr;
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        model_start(l);
        chk("first_draw.A", 32'(bus0.A), 32'h5);
        chk("first_draw.B", 32'(bus0.B), 32'h2);
        chk_all("first_draw");

        press("wrong_a", 4'h3, 1'b0, 100);
        press("right_a", 4'h5, 1'b0, 0);
        do_start("start_in_b");
        enable = 1'b0;
        press("disabled", 4'hA, 1'b0, 0);
        enable = 1'b1;
        press("right_b", 4'hA, 1'b0, 0);
        press("after_win", 4'h3, 1'b0, 0);
        do_start("back_idle");

        // explosion on the 2-attempt controller
        repeat ($urandom_range(1, 20)) @(negedge CLOCK);
        do_start("round2");
        press("boom1", wrong_a(), 1'b0, 0);
        press("boom2", wrong_a(), 1'b0, 0);
        press("boom3", wrong_a(), 1'b0, 0);

        // START and ENTER_VALIDO in the same cycle from idle
        @(negedge CLOCK);
        RESET = 1'b0;
        model_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge CLOCK);
        press("coincident", 4'($urandom_range(0, 15)), 1'b1, 0);
        press("to_b", m_a[0], 1'b0, 0);

        // reset in the middle of a debounce in phase B
        tent = 4'($urandom_range(0, 15));
        @(negedge CLOCK);
        enter = 1'b1;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        model_reset();
        chk_all("reset_mid");
        enter = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge CLOCK);
            if (bus0.ENTER_VALIDO || bus1.ENTER_VALIDO) cnt++;
        end
        chk("reset_mid.no_pulse", 32'(cnt), 32'd0);
        chk_all("after_reset");

        // random rounds
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 30)) @(negedge CLOCK);
            do_start($sformatf("rnd%0d.s1", r));
            do_start($sformatf("rnd%0d.s2", r));
            for (int p = 0; p < 6; p++) begin
                if ($urandom_range(0, 2) == 0)
                    t = (m_ph[0] == P_B) ? {1'($urandom_range(0, 1)), m_b[0]} : m_a[0];
                else
                    t = 4'($urandom_range(0, 15));
                press($sformatf("rnd%0d.p%0d", r, p), t, 1'b0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
